dbg_cmd_parser: RTL and testbench
=================================

// Module: dbg_cmd_parser
//
// PURPOSE
//   Assembles debug commands from a UART byte-receiver stream.
//   Decodes a leading opcode byte, collects the number of address and data
//   bytes that opcode requires, and presents the whole command on a
//   valid/ready interface to the debug bus master.
//   Reports inter-byte timeouts, framing errors, unknown opcodes and overruns
//   as one-cycle error events with a code. Sits between uart_rx and the
//   debug bus engine.
//
// PARAMETERS
//   AdrW             4   address field width in bytes (>=1)
//   DatW             4   data field width in bytes (>=1)
//   TimeoutInCycles  8   max idle cycles between bytes of one command; 0 disables timeout
//
// PORTS
//   clk           in   1        system clock
//   rst           in   1        synchronous reset, active-high
//   recv_valid    in   1        one-cycle strobe: recv_data holds a received byte
//   recv_data     in   8        received byte
//   recv_error    in   1        one-cycle strobe: receiver framing/parity error
//   cmd_valid     out  1        command available; held until accepted
//   cmd_ready     in   1        consumer accepts when cmd_valid && cmd_ready
//   cmd_op        out  2        0=PING 1=READ 2=WRITE
//   cmd_addr      out  AdrW*8   address, first received byte = MSB
//   cmd_data      out  DatW*8   write data, first received byte = MSB; 0 unless WRITE
//   busy          out  1        state != IDLE
//   err_valid     out  1        one-cycle error event
//   err_code      out  2        1=FRAME 2=TIMEOUT 3=BAD_OPCODE (0 = OVERRUN)
//
// BEHAVIOUR
//   Reset: state=IDLE; cmd_valid=0, cmd_op=0, cmd_addr=0, cmd_data=0, busy=0,
//     err_valid=0, err_code=0; all counters cleared. Reset mid-command discards
//     partial bytes.
//   Opcodes (first byte):
//     0x50 PING  -> 0 further bytes
//     0x52 READ  -> AdrW bytes
//     0x57 WRITE -> AdrW+DatW bytes
//     Any other value -> BAD_OPCODE.
//   States:
//     IDLE    -> on recv_valid with a valid opcode: latch op, clear addr/data,
//                load the remaining-byte count, then COLLECT (HOLD if PING).
//     COLLECT -> each recv_valid shifts the byte into addr (first AdrW bytes),
//                then into data. The last byte goes to HOLD.
//     HOLD    -> cmd_valid=1, fields stable. A handshake returns to IDLE on
//                the next cycle.
//   Latency: cmd_valid rises the cycle after the final byte's recv_valid.
//     For PING, this is the cycle after the opcode.
//   Timeout: counter clears on entry to COLLECT and on every recv_valid, and
//     increments on other COLLECT cycles. When it reaches TimeoutInCycles,
//     raise TIMEOUT and go to IDLE.
//   Errors: err_valid/err_code are registered, asserted the cycle after the
//     causing input. Any error in COLLECT returns to IDLE and drops partial
//     data. recv_error in IDLE raises FRAME and stays in IDLE. A bad opcode
//     stays in IDLE.
//   Overrun: recv_valid in HOLD drops the byte, raises code 0 (OVERRUN), and
//     keeps HOLD with the held command unchanged.
//   Simultaneous events:
//     - recv_error and recv_valid in the same cycle: error wins, byte discarded.
//     - Timeout and recv_valid in the same cycle: byte wins, counter clears.
//     - HOLD handshake and recv_valid in the same cycle: command is accepted
//       and the byte raises OVERRUN (it is not taken as an opcode).
//   Width rules: byte counter sized $clog2(AdrW+DatW+1)+1; timeout counter
//     sized $clog2(TimeoutInCycles+1)+1. No wrap is possible.
//
// TESTING
//   1. AdrW=4,DatW=4: bytes 57 00 00 10 00 DE AD BE EF, ready=1 ->
//      cmd_valid one cycle after 0xEF, op=2, addr=0x00001000, data=0xDEADBEEF.
//   2. Bytes 52 12 34 56 78 with cmd_ready=0 for 5 cycles -> cmd_valid held
//      with addr=0x12345678, data=0; after accept, busy=0 next cycle.
//   3. Byte 52 then 9 idle cycles (TimeoutInCycles=8) -> err_valid with code 2
//      exactly once; state IDLE; no cmd_valid.
//   4. Byte 0x41 -> err_code 3 next cycle. Then byte 50 -> cmd_op=0 one cycle
//      after the 50.
//   5. recv_error during 3rd byte of WRITE -> err_code 1, partial dropped. A
//      following full READ decodes correctly. Also check recv_error+recv_valid
//      in the same cycle -> FRAME only.
//   6. In HOLD with cmd_ready=0, send byte 0x57 -> err_code 0, held fields
//      unchanged. Also check rst asserted mid-COLLECT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dbg_cmd_parser.sv
// Debug command assembler: turns a UART byte stream into opcode/address/data
// commands on a valid/ready interface, with registered one-cycle error events.
module dbg_cmd_parser #(
  parameter int AdrW            = 4,
  parameter int DatW            = 4,
  parameter int TimeoutInCycles = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                recv_valid_i,
  input  logic [7:0]          recv_data_i,
  input  logic                recv_error_i,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output logic [1:0]          cmd_op_o,
  output logic [AdrW*8-1:0]   cmd_addr_o,
  output logic [DatW*8-1:0]   cmd_data_o,
  output logic                busy_o,
  output logic                err_valid_o,
  output logic [1:0]          err_code_o
);

  localparam int CW = $clog2(AdrW + DatW + 1) + 1;
  localparam int TW = $clog2(TimeoutInCycles + 1) + 1;

  localparam logic [CW-1:0] ADR_N = CW'(AdrW);
  localparam logic [CW-1:0] TOT_N = CW'(AdrW + DatW);
  localparam logic [TW-1:0] TO_N  = TW'(TimeoutInCycles);

  localparam logic [7:0] BYTE_PING  = 8'h50;
  localparam logic [7:0] BYTE_READ  = 8'h52;
  localparam logic [7:0] BYTE_WRITE = 8'h57;

  localparam logic [1:0] OP_PING  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BADOP   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [AdrW*8-1:0]   addr_q, addr_d;
  logic [DatW*8-1:0]   data_q, data_d;
  logic [CW-1:0]       idx_q, idx_d;    // bytes collected after the opcode
  logic [CW-1:0]       need_q, need_d;  // bytes this opcode requires
  logic [TW-1:0]       to_q, to_d;      // idle cycles since last byte
  logic                errv_q, errv_d;
  logic [1:0]          errc_q, errc_d;

  // Shifted views: new byte enters at the LSB so the first byte ends up MSB.
  logic [AdrW*8+7:0]   addr_sh;
  logic [DatW*8+7:0]   data_sh;
  assign addr_sh = {addr_q, recv_data_i};
  assign data_sh = {data_q, recv_data_i};

  // State and field registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      need_q  <= '0;
      to_q    <= '0;
      errv_q  <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      need_q  <= need_d;
      to_q    <= to_d;
      errv_q  <= errv_d;
      errc_q  <= errc_d;
    end
  end

  // Next-state: opcode decode, byte collection, timeout and error arbitration.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    need_d  = need_q;
    to_d    = to_q;
    errv_d  = 1'b0;
    errc_d  = errc_q;

    case (state_q)
      S_IDLE: begin
        if (recv_error_i) begin
          errv_d = 1'b1;
          errc_d = ERR_FRAME;
        end else if (recv_valid_i) begin
          addr_d = '0;
          data_d = '0;
          idx_d  = '0;
          to_d   = '0;
          case (recv_data_i)
            BYTE_PING: begin
              op_d    = OP_PING;
              need_d  = '0;
              state_d = S_HOLD;
            end
            BYTE_READ: begin
              op_d    = OP_READ;
              need_d  = ADR_N;
              state_d = S_COLLECT;
            end
            BYTE_WRITE: begin
              op_d    = OP_WRITE;
              need_d  = TOT_N;
              state_d = S_COLLECT;
            end
            default: begin
              // Unknown opcode leaves the previous fields untouched.
              addr_d = addr_q;
              data_d = data_q;
              errv_d = 1'b1;
              errc_d = ERR_BADOP;
            end
          endcase
        end
      end

      S_COLLECT: begin
        if (recv_error_i) begin
          // Error beats a simultaneous byte; partial command is dropped.
          errv_d  = 1'b1;
          errc_d  = ERR_FRAME;
          addr_d  = '0;
          data_d  = '0;
          state_d = S_IDLE;
        end else if (recv_valid_i) begin
          // A byte beats a simultaneous timeout.
          to_d = '0;
          if (idx_q < ADR_N) addr_d = addr_sh[AdrW*8-1:0];
          else               data_d = data_sh[DatW*8-1:0];
          idx_d = idx_q + CW'(1);
          if (idx_q + CW'(1) == need_q) state_d = S_HOLD;
        end else if (TimeoutInCycles != 0) begin
          if (to_q == TO_N) begin
            errv_d  = 1'b1;
            errc_d  = ERR_TIMEOUT;
            addr_d  = '0;
            data_d  = '0;
            state_d = S_IDLE;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
      end

      S_HOLD: begin
        if (cmd_ready_i) state_d = S_IDLE;
        // Bytes arriving while a command is held are never taken as opcodes.
        if (recv_error_i) begin
          errv_d = 1'b1;
          errc_d = ERR_FRAME;
        end else if (recv_valid_i) begin
          errv_d = 1'b1;
          errc_d = ERR_OVERRUN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_valid_o = (state_q == S_HOLD);
  assign busy_o      = (state_q != S_IDLE);
  assign cmd_op_o    = op_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_data_o  = data_q;
  assign err_valid_o = errv_q;
  assign err_code_o  = errc_q;

endmodule

// File: tb/tb_dbg_cmd_parser.sv
// Directed and randomized bench for dbg_cmd_parser against a byte-queue model.
module tb_dbg_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        recv_valid = 1'b0;
  logic [7:0]  recv_data = 8'h00;
  logic        recv_error = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        busy;
  logic        err_valid;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbg_cmd_parser #(.AdrW(4), .DatW(4), .TimeoutInCycles(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .recv_valid_i (recv_valid),
    .recv_data_i  (recv_data),
    .recv_error_i (recv_error),
    .cmd_valid_o  (cmd_valid),
    .cmd_ready_i  (cmd_ready),
    .cmd_op_o     (cmd_op),
    .cmd_addr_o   (cmd_addr),
    .cmd_data_o   (cmd_data),
    .busy_o       (busy),
    .err_valid_o  (err_valid),
    .err_code_o   (err_code)
  );

  // Reference model: the command being gathered is a queue of raw bytes
  // (opcode first); a finished command is held until accepted.
  logic [7:0]  mq[$];
  bit          m_hold = 0;
  int          m_idle = 0;
  logic [1:0]  m_op = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_data = 0;
  bit          e_v = 0;
  logic [1:0]  e_c = 0;
  int          tmo_seen = 0;

  function automatic int need_of(input logic [7:0] b);
    case (b)
      8'h50:   return 0;
      8'h52:   return 4;
      8'h57:   return 8;
      default: return -1;
    endcase
  endfunction

  function automatic logic [1:0] op_of(input logic [7:0] b);
    return (b == 8'h50) ? 2'd0 : (b == 8'h52) ? 2'd1 : 2'd2;
  endfunction

  task automatic finish_cmd();
    m_op = op_of(mq[0]);
    m_addr = 0;
    m_data = 0;
    for (int i = 1; i < mq.size(); i++) begin
      if (i <= 4) m_addr = m_addr * 256 + 32'(mq[i]);
      else        m_data = m_data * 256 + 32'(mq[i]);
    end
    mq.delete();
    m_hold = 1;
  endtask

  task automatic model(input bit rv, input logic [7:0] d, input bit re, input bit rdy, input bit r);
    e_v = 0;
    if (r) begin
      mq.delete(); m_hold = 0; m_idle = 0;
      m_op = 0; m_addr = 0; m_data = 0; e_c = 0;
    end else if (m_hold) begin
      if (re)      begin e_v = 1; e_c = 1; end
      else if (rv) begin e_v = 1; e_c = 0; end
      if (rdy) m_hold = 0;
    end else if (mq.size() == 0) begin
      if (re) begin e_v = 1; e_c = 1; end
      else if (rv) begin
        if (need_of(d) < 0) begin e_v = 1; e_c = 3; end
        else begin
          mq.push_back(d);
          m_idle = 0;
          if (need_of(d) == 0) finish_cmd();
        end
      end
    end else begin
      if (re) begin e_v = 1; e_c = 1; mq.delete(); end
      else if (rv) begin
        mq.push_back(d);
        m_idle = 0;
        if (mq.size() - 1 == need_of(mq[0])) finish_cmd();
      end else if (m_idle == 8) begin
        e_v = 1; e_c = 2; mq.delete();
      end else m_idle++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model, compare outputs 1 time unit later.
  task automatic step(input bit rv, input logic [7:0] d, input bit re, input bit rdy, input bit r);
    rst = r; recv_valid = rv; recv_data = d; recv_error = re; cmd_ready = rdy;
    @(posedge clk);
    model(rv, d, re, rdy, r);
    #1;
    chk("cmd_valid", 64'(cmd_valid), 64'(m_hold));
    chk("busy", 64'(busy), 64'(m_hold || mq.size() != 0));
    chk("err_valid", 64'(err_valid), 64'(e_v));
    if (e_v) chk("err_code", 64'(err_code), 64'(e_c));
    if (err_valid && err_code == 2'd2) tmo_seen++;
    if (m_hold) begin
      chk("cmd_op", 64'(cmd_op), 64'(m_op));
      chk("cmd_addr", 64'(cmd_addr), 64'(m_addr));
      chk("cmd_data", 64'(cmd_data), 64'(m_data));
    end
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    step(1, b, 0, rdy, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, rdy, 0);
  endtask

  task automatic zeros(input string tag);
    chk({tag, "_op"},   64'(cmd_op),   64'd0);
    chk({tag, "_addr"}, 64'(cmd_addr), 64'd0);
    chk({tag, "_data"}, 64'(cmd_data), 64'd0);
    chk({tag, "_ecode"}, 64'(err_code), 64'd0);
  endtask

  initial begin
    logic [7:0] w1 [9];
    logic [7:0] b;
    int k;
    w1 = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    // Reset state
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    zeros("reset");

    // 1: full WRITE with consumer always ready
    for (int i = 0; i < 9; i++) send(w1[i], 1);
    chk("t1_valid", 64'(cmd_valid), 64'd1);
    chk("t1_op", 64'(cmd_op), 64'd2);
    chk("t1_addr", 64'(cmd_addr), 64'h0000_1000);
    chk("t1_data", 64'(cmd_data), 64'hDEAD_BEEF);
    idle(2, 1);

    // 2: READ held under back-pressure, then accepted
    send(8'h52, 0); send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    idle(5, 0);
    chk("t2_addr", 64'(cmd_addr), 64'h1234_5678);
    chk("t2_data", 64'(cmd_data), 64'd0);
    idle(1, 1);
    chk("t2_busy", 64'(busy), 64'd0);

    // 3: lone READ opcode times out exactly once
    tmo_seen = 0;
    send(8'h52, 1);
    idle(12, 1);
    chk("t3_tmo_count", 64'(tmo_seen), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);

    // 4: bad opcode, then PING
    send(8'h41, 0);
    chk("t4_badop", 64'(err_code), 64'd3);
    send(8'h50, 0);
    chk("t4_ping_op", 64'(cmd_op), 64'd0);
    idle(2, 1);

    // 5: framing error mid-WRITE, following READ, then error+byte together
    send(8'h57, 1); send(8'h00, 1);
    step(0, 8'h00, 1, 1, 0);
    chk("t5_frame", 64'(err_code), 64'd1);
    send(8'h52, 1); send(8'hAA, 1); send(8'hBB, 1); send(8'hCC, 1); send(8'hDD, 1);
    chk("t5_read_addr", 64'(cmd_addr), 64'hAABB_CCDD);
    idle(1, 1);
    step(1, 8'h52, 1, 1, 0);
    chk("t5_both_code", 64'(err_code), 64'd1);
    idle(1, 1);
    chk("t5_both_busy", 64'(busy), 64'd0);

    // 6: overrun while held, handshake+byte, reset mid-collect
    send(8'h52, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h57, 0);
    chk("t6_ovr_code", 64'(err_code), 64'd0);
    chk("t6_ovr_addr", 64'(cmd_addr), 64'h0102_0304);
    step(1, 8'h50, 0, 1, 0);
    chk("t6_hs_ovr", 64'(err_valid), 64'd1);
    idle(1, 0);
    send(8'h57, 0); send(8'h11, 0); send(8'h22, 0);
    step(0, 8'h00, 0, 0, 1);
    zeros("t6_rst");
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_valid", 64'(cmd_valid), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) idle(10, $urandom_range(0, 1));
      k = $urandom_range(0, 9);
      b = (k == 0) ? 8'h50 : (k == 1) ? 8'h52 : (k <= 3) ? 8'h57 : 8'($urandom);
      step($urandom_range(0, 9) < 4, b, $urandom_range(0, 39) == 0,
           $urandom_range(0, 1), $urandom_range(0, 499) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
